vc_fifo_pop: RTL and testbench

- Input buffer stage that sits directly upstream of the two-way VC demux.
- Stores incoming words in a small circular FIFO and decides when the head word may be popped.
- On a pop it presents the word together with a one-cycle pop strobe and a VC selector taken from the word's MSB.
- It withholds pops while the destination VC's downstream buffer reports almost-full.

---
 rtl/vc_fifo_pop.sv | 125 ++++++++++++
 tb/tb_vc_fifo_pop.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vc_fifo_pop.sv
// Input FIFO ahead of the two-way VC demux: pops the head word when its VC has room downstream.
// Define VC_FIFO_STATS_EN to compile the per-VC saturating pop counters (otherwise tied to 0).
module vc_fifo_pop #(
    parameter int DATA_SIZE = 6,
    parameter int ADDR_SIZE = 2,
    parameter int AF_TH     = 3,
    parameter int AE_TH     = 1
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 af_vc0,
    input  logic                 af_vc1,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 en_pop,
    output logic                 selector,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 error,
    output logic [7:0]           cnt_vc0,
    output logic [7:0]           cnt_vc1
);

    localparam int                 DEPTH   = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE+1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] AF_C    = (ADDR_SIZE+1)'(AF_TH);
    localparam logic [ADDR_SIZE:0] AE_C    = (ADDR_SIZE+1)'(AE_TH);
    localparam logic [ADDR_SIZE:0] CNT_ONE = (ADDR_SIZE+1)'(1);
    localparam logic [ADDR_SIZE-1:0] PTR_ONE = ADDR_SIZE'(1);

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic [ADDR_SIZE:0]   count;

    logic [DATA_SIZE-1:0] head_p0;
    logic                 head_vc_p0;
    logic                 blocked_p0;
    logic                 can_pop;
    logic                 push_ok;

    // Head lookup and pop decision, all from state sampled at this edge
    assign head_p0    = mem[rd_ptr];
    assign head_vc_p0 = head_p0[DATA_SIZE-1];
    assign blocked_p0 = head_vc_p0 ? af_vc1 : af_vc0;
    assign can_pop    = (count != '0) && !blocked_p0;
    // A push into a full FIFO is dropped even if a pop frees a slot this cycle
    assign push_ok    = push && (count != DEPTH_C);

    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            error  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (can_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !push_ok) begin
                error <= 1'b1;
            end
            case ({push_ok, can_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Registered pop stage towards the demux
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            en_pop   <= 1'b0;
            data_out <= '0;
            selector <= 1'b0;
        end else begin
            en_pop <= can_pop;
            if (can_pop) begin
                data_out <= head_p0;
                selector <= head_vc_p0;
            end
        end
    end

`ifdef VC_FIFO_STATS_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_vc0 <= '0;
            cnt_vc1 <= '0;
        end else if (can_pop) begin
            if (head_vc_p0) begin
                cnt_vc1 <= sat_inc(cnt_vc1);
            end else begin
                cnt_vc0 <= sat_inc(cnt_vc0);
            end
        end
    end
`else
    assign cnt_vc0 = '0;
    assign cnt_vc1 = '0;
`endif

endmodule

// File: tb/tb_vc_fifo_pop.sv
// Directed bench for vc_fifo_pop with hand-computed expectations.
module tb_vc_fifo_pop;

    logic       clk;
    logic       reset_L;
    logic       push;
    logic [5:0] data_in;
    logic       af_vc0;
    logic       af_vc1;
    logic [5:0] data_out;
    logic       en_pop;
    logic       selector;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       error;
    logic [7:0] cnt_vc0;
    logic [7:0] cnt_vc1;

    int tests_run;
    int tests_failed;

    vc_fifo_pop dut (
        .clk(clk),
        .reset_L(reset_L),
        .push(push),
        .data_in(data_in),
        .af_vc0(af_vc0),
        .af_vc1(af_vc1),
        .data_out(data_out),
        .en_pop(en_pop),
        .selector(selector),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .error(error),
        .cnt_vc0(cnt_vc0),
        .cnt_vc1(cnt_vc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pop(input string tag, input logic [5:0] d, input logic s);
        tick();
        check({tag, ".en_pop"}, 32'(en_pop), 32'd1);
        check({tag, ".data"}, 32'(data_out), 32'(d));
        check({tag, ".sel"}, 32'(selector), 32'(s));
    endtask

    task automatic push_word(input logic [5:0] d);
        push    = 1'b1;
        data_in = d;
        tick();
        push    = 1'b0;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        #1;
        reset_L = 1'b1;
        tick();
    endtask

    logic [5:0] fill_words [4];
    logic [7:0] exp_cnt0;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_L = 1'b0;
        push    = 1'b0;
        data_in = '0;
        af_vc0  = 1'b0;
        af_vc1  = 1'b0;
        fill_words[0] = 6'h01;
        fill_words[1] = 6'h02;
        fill_words[2] = 6'h03;
        fill_words[3] = 6'h04;
        #1;
        check("rst.en_pop", 32'(en_pop), 32'd0);
        check("rst.empty", 32'(empty), 32'd1);
        check("rst.aempty", 32'(almost_empty), 32'd1);
        check("rst.full", 32'(full), 32'd0);
        check("rst.afull", 32'(almost_full), 32'd0);
        check("rst.error", 32'(error), 32'd0);
        check("rst.data", 32'(data_out), 32'd0);
        check("rst.sel", 32'(selector), 32'd0);
        check("rst.cnt0", 32'(cnt_vc0), 32'd0);
        check("rst.cnt1", 32'(cnt_vc1), 32'd0);
        tick();
        tick();
        reset_L = 1'b1;
        tick();

        // Single word: no pop on the push edge, one-cycle strobe on the next
        push_word(6'h05);
        check("t1.no_bypass", 32'(en_pop), 32'd0);
        check("t1.not_empty", 32'(empty), 32'd0);
        expect_pop("t1.pop", 6'h05, 1'b0);
        check("t1.empty_after", 32'(empty), 32'd1);
        tick();
        check("t1.strobe_drop", 32'(en_pop), 32'd0);
        check("t1.data_hold", 32'(data_out), 32'h05);

        // Four words with pops blocked, then drain in order
        af_vc0 = 1'b1;
        af_vc1 = 1'b1;
        push_word(6'h21);
        push_word(6'h02);
        push_word(6'h23);
        check("t2.afull_at3", 32'(almost_full), 32'd1);
        check("t2.not_full3", 32'(full), 32'd0);
        push_word(6'h04);
        check("t2.full", 32'(full), 32'd1);
        af_vc0 = 1'b0;
        af_vc1 = 1'b0;
        expect_pop("t2.p0", 6'h21, 1'b1);
        expect_pop("t2.p1", 6'h02, 1'b0);
        expect_pop("t2.p2", 6'h23, 1'b1);
        expect_pop("t2.p3", 6'h04, 1'b0);
        tick();
        check("t2.idle", 32'(en_pop), 32'd0);
        check("t2.empty", 32'(empty), 32'd1);
        check("t2.error", 32'(error), 32'd0);

        // Overflow while blocked, then push-at-full alongside a pop
        af_vc0 = 1'b1;
        af_vc1 = 1'b1;
        for (int i = 0; i < 4; i++) push_word(fill_words[i]);
        push_word(6'h3F);
        check("t3.error", 32'(error), 32'd1);
        check("t3.still_full", 32'(full), 32'd1);
        check("t3.no_pop", 32'(en_pop), 32'd0);
        af_vc0 = 1'b0;
        af_vc1 = 1'b0;
        push_word(6'h3E);
        check("t3.pop_at_full", 32'(en_pop), 32'd1);
        check("t3.pop_data", 32'(data_out), 32'h01);
        check("t3.count3_full", 32'(full), 32'd0);
        check("t3.count3_afull", 32'(almost_full), 32'd1);
        expect_pop("t3.p1", 6'h02, 1'b0);
        expect_pop("t3.p2", 6'h03, 1'b0);
        expect_pop("t3.p3", 6'h04, 1'b0);
        tick();
        check("t3.drained", 32'(empty), 32'd1);
        check("t3.no_3x", 32'(en_pop), 32'd0);
        check("t3.error_sticky", 32'(error), 32'd1);
        do_reset();
        check("t3.error_clr", 32'(error), 32'd0);

        // Blocked VC1 head holds back a VC0 word behind it
        af_vc1 = 1'b1;
        push_word(6'h20);
        push_word(6'h05);
        for (int i = 0; i < 5; i++) begin
            check("t4.blocked", 32'(en_pop), 32'd0);
            tick();
        end
        af_vc1 = 1'b0;
        expect_pop("t4.p0", 6'h20, 1'b1);
        expect_pop("t4.p1", 6'h05, 1'b0);
        tick();
        check("t4.idle", 32'(en_pop), 32'd0);

        // Push and pop on the same edge at count 2
        af_vc0 = 1'b1;
        push_word(6'h11);
        push_word(6'h12);
        af_vc0 = 1'b0;
        push_word(6'h13);
        check("t5.pop", 32'(en_pop), 32'd1);
        check("t5.data", 32'(data_out), 32'h11);
        check("t5.afull", 32'(almost_full), 32'd0);
        check("t5.aempty", 32'(almost_empty), 32'd0);
        check("t5.empty", 32'(empty), 32'd0);
        expect_pop("t5.p1", 6'h12, 1'b0);
        expect_pop("t5.p2", 6'h13, 1'b0);

        // Asynchronous reset mid-stream: count 3, pop in flight, error set
        af_vc0 = 1'b1;
        for (int i = 0; i < 4; i++) push_word(fill_words[i]);
        push_word(6'h3F);
        af_vc0 = 1'b0;
        tick();
        check("t6.pre_pop", 32'(en_pop), 32'd1);
        check("t6.pre_error", 32'(error), 32'd1);
        reset_L = 1'b0;
        #1;
        check("t6.en_pop", 32'(en_pop), 32'd0);
        check("t6.empty", 32'(empty), 32'd1);
        check("t6.error", 32'(error), 32'd0);
        check("t6.data", 32'(data_out), 32'd0);
        #2;
        reset_L = 1'b1;
        tick();
        check("t6.post_idle", 32'(en_pop), 32'd0);

        // 300 VC0 pops for the saturating statistics
        push    = 1'b1;
        data_in = 6'h01;
        for (int i = 0; i < 300; i++) tick();
        push = 1'b0;
        tick();
        tick();
        check("t7.empty", 32'(empty), 32'd1);
`ifdef VC_FIFO_STATS_EN
        exp_cnt0 = 8'd255;
`else
        exp_cnt0 = 8'd0;
`endif
        check("t7.cnt_vc0", 32'(cnt_vc0), 32'(exp_cnt0));
        check("t7.cnt_vc1", 32'(cnt_vc1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
